// File: rtl/regfile_write_scheduler_pkg.sv
// Shared sizing constants and writeback source encoding for the register file
// write scheduler.
package regfile_write_scheduler_pkg;

  localparam int NUM_REGS = 64;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;

  // Source encoding doubles as the bit index into request/grant vectors.
  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_write_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, 1-bit pointer
// remembering the most recently granted source.
module rr_arbiter2
  import regfile_write_scheduler_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  src_e r_last;

  always_comb begin
    o_grant = 2'b00;
    if (!i_rst) begin
      unique case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        // Contention: favour whichever source did not win last time.
        2'b11:   o_grant = (r_last == SRC_ALU) ? 2'b10 : 2'b01;
        default: o_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= SRC_ALU;
    end else if (o_grant[SRC_LOAD]) begin
      r_last <= SRC_LOAD;
    end else if (o_grant[SRC_ALU]) begin
      r_last <= SRC_ALU;
    end
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU/load writebacks onto the single register file write port and
// tracks destination reservations to stall issue on RAW/WAW hazards.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_rs1,
  input  logic [ADDR_W-1:0] i_issue_rs2,
  input  logic [ADDR_W-1:0] i_issue_rd,
  output logic              o_issue_ready,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_rd,
  input  logic [DATA_W-1:0] i_alu_data,
  output logic              o_alu_ready,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_rd,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic              o_ld_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_idle
);

  logic [NUM_REGS-1:0] r_busy;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;

  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic                w_any_grant;
  logic [ADDR_W-1:0]   w_sel_rd;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_issue_fire;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;
  logic [NUM_REGS-1:0] w_busy_next;

  assign w_req = {i_ld_valid, i_alu_valid};

  rr_arbiter2 u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (w_req),
    .o_grant (w_grant)
  );

  assign o_alu_ready = w_grant[SRC_ALU];
  assign o_ld_ready  = w_grant[SRC_LOAD];
  assign w_any_grant = |w_grant;
  assign w_sel_rd    = w_grant[SRC_LOAD] ? i_ld_rd   : i_alu_rd;
  assign w_sel_data  = w_grant[SRC_LOAD] ? i_ld_data : i_alu_data;

  // Stall on current-cycle reservations only; a clear this cycle unstalls next cycle.
  assign o_issue_ready = !i_rst &&
                         !(r_busy[i_issue_rs1] || r_busy[i_issue_rs2] || r_busy[i_issue_rd]);
  assign w_issue_fire  = i_issue_valid && o_issue_ready;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_issue_fire && (i_issue_rd != '0)) w_set_mask[i_issue_rd] = 1'b1;
    if (r_wr_en)                            w_clr_mask[r_wr_addr]  = 1'b1;
    // NOTE: the set is OR-ed in after the clear, so a same-cycle set/clear leaves the bit set.
    w_busy_next    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_busy  <= w_busy_next;
      // Writes to r0 are accepted upstream but never reach the port.
      r_wr_en <= w_any_grant && (w_sel_rd != '0);
      if (w_any_grant) begin
        r_wr_addr <= w_sel_rd;
        r_wr_data <= w_sel_data;
      end
    end
  end

  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;
  assign o_idle    = (r_busy == '0) && !r_wr_en;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler: reset, RAW/WAW stalls, round-robin
// arbitration, r0 handling and mid-operation reset.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [5:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_ready;
  logic        alu_valid;
  logic [5:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [5:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        idle;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_issue_valid (issue_valid),
    .i_issue_rs1   (issue_rs1),
    .i_issue_rs2   (issue_rs2),
    .i_issue_rd    (issue_rd),
    .o_issue_ready (issue_ready),
    .i_alu_valid   (alu_valid),
    .i_alu_rd      (alu_rd),
    .i_alu_data    (alu_data),
    .o_alu_ready   (alu_ready),
    .i_ld_valid    (ld_valid),
    .i_ld_rd       (ld_rd),
    .i_ld_data     (ld_data),
    .o_ld_ready    (ld_ready),
    .o_wr_en       (wr_en),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_idle        (idle)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    issue_valid = 1'b1; issue_rd = 6'd5;
    alu_valid = 1'b1; alu_rd = 6'd1; ld_valid = 1'b1; ld_rd = 6'd2;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL rst_issue_ready got=%b exp=0", issue_ready); end
    n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL rst_alu_ready got=%b exp=0", alu_ready); end
    n_checks++; if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ld_ready got=%b exp=0", ld_ready); end
    tick(); tick();
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    n_checks++; if (wr_addr !== 6'd0) begin n_errors++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
    n_checks++; if (wr_data !== 32'd0) begin n_errors++; $display("FAIL rst_wr_data got=%h exp=0", wr_data); end
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL rst_idle got=%b exp=1", idle); end
    rst = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL post_rst_issue_ready got=%b exp=1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++; if (idle !== 1'b0) begin n_errors++; $display("FAIL r5_reserved_idle got=%b exp=0", idle); end
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL r5_reserved_wr_en got=%b exp=0", wr_en); end
  endtask

  task automatic test_raw();
    issue_valid = 1'b1; issue_rs1 = 6'd5; issue_rs2 = 6'd0; issue_rd = 6'd0;
    alu_valid = 1'b1; alu_rd = 6'd5; alu_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL raw_stall got=%b exp=0", issue_ready); end
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL raw_alu_ready got=%b exp=1", alu_ready); end
    n_checks++; if (ld_ready !== 1'b0) begin n_errors++; $display("FAIL raw_ld_ready got=%b exp=0", ld_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b1) begin n_errors++; $display("FAIL raw_wr_en got=%b exp=1", wr_en); end
    n_checks++; if (wr_addr !== 6'd5) begin n_errors++; $display("FAIL raw_wr_addr got=%0d exp=5", wr_addr); end
    n_checks++; if (wr_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL raw_wr_data got=%h exp=deadbeef", wr_data); end
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL raw_no_bypass got=%b exp=0", issue_ready); end
    tick();
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL raw_wr_en_drop got=%b exp=0", wr_en); end
    n_checks++; if (wr_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL raw_wr_data_hold got=%h exp=deadbeef", wr_data); end
    n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL raw_unstall got=%b exp=1", issue_ready); end
    tick();
    issue_valid = 1'b0;
    #1;
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL raw_idle got=%b exp=1", idle); end
  endtask

  task automatic test_round_robin();
    // Last grant was the ALU (r5), so contention starts with the load unit.
    logic [5:0] alu_list [2] = '{6'd1, 6'd3};
    logic [5:0] ld_list  [3] = '{6'd2, 6'd4, 6'd6};
    logic       exp_ld   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int ai = 0;
    int li = 0;
    logic [5:0]  exp_addr;
    logic [31:0] exp_data;
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1'b1; alu_rd = alu_list[ai]; alu_data = 32'hA000_0000 | 32'(alu_list[ai]);
      ld_valid  = 1'b1; ld_rd  = ld_list[li];  ld_data  = 32'hB000_0000 | 32'(ld_list[li]);
      #1;
      n_checks++; if (ld_ready !== exp_ld[c]) begin n_errors++; $display("FAIL rr_ld_grant c=%0d got=%b exp=%b", c, ld_ready, exp_ld[c]); end
      n_checks++; if (alu_ready !== !exp_ld[c]) begin n_errors++; $display("FAIL rr_alu_grant c=%0d got=%b exp=%b", c, alu_ready, !exp_ld[c]); end
      if (exp_ld[c]) begin
        exp_addr = ld_list[li]; exp_data = 32'hB000_0000 | 32'(ld_list[li]); li++;
      end else begin
        exp_addr = alu_list[ai]; exp_data = 32'hA000_0000 | 32'(alu_list[ai]); ai++;
      end
      tick();
      n_checks++; if (wr_en !== 1'b1) begin n_errors++; $display("FAIL rr_wr_en c=%0d got=%b exp=1", c, wr_en); end
      n_checks++; if (wr_addr !== exp_addr) begin n_errors++; $display("FAIL rr_wr_addr c=%0d got=%0d exp=%0d", c, wr_addr, exp_addr); end
      n_checks++; if (wr_data !== exp_data) begin n_errors++; $display("FAIL rr_wr_data c=%0d got=%h exp=%h", c, wr_data, exp_data); end
    end
    // Pointer now says ALU won last; a lone ALU request must still be granted.
    ld_valid = 1'b0;
    alu_rd = 6'd8; alu_data = 32'h0000_0088;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL rr_single_alu got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++; if (wr_addr !== 6'd8) begin n_errors++; $display("FAIL rr_single_addr got=%0d exp=8", wr_addr); end
    tick();
  endtask

  task automatic test_rd_zero();
    issue_valid = 1'b1; issue_rs1 = 6'd0; issue_rs2 = 6'd0; issue_rd = 6'd0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL rd0_issue_ready got=%b exp=1", issue_ready); end
    tick();
    n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL rd0_no_reserve got=%b exp=1", issue_ready); end
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL rd0_idle got=%b exp=1", idle); end
    issue_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 6'd0; ld_data = 32'h1234_5678;
    #1;
    n_checks++; if (ld_ready !== 1'b1) begin n_errors++; $display("FAIL rd0_ld_ready got=%b exp=1", ld_ready); end
    tick();
    ld_valid = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL rd0_wr_en got=%b exp=0", wr_en); end
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL rd0_wr_idle got=%b exp=1", idle); end
  endtask

  task automatic test_waw();
    issue_valid = 1'b1; issue_rs1 = 6'd0; issue_rs2 = 6'd0; issue_rd = 6'd7;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL waw_first got=%b exp=1", issue_ready); end
    tick();
    issue_rs1 = 6'd1;
    alu_valid = 1'b1; alu_rd = 6'd7; alu_data = 32'h0000_0077;
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL waw_stall got=%b exp=0", issue_ready); end
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL waw_alu_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 1'b0;
    #1;
    n_checks++; if (wr_en !== 1'b1 || wr_addr !== 6'd7) begin n_errors++; $display("FAIL waw_write got=%b/%0d exp=1/7", wr_en, wr_addr); end
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL waw_stall_during_write got=%b exp=0", issue_ready); end
    tick();
    n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL waw_release got=%b exp=1", issue_ready); end
    issue_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rs1 = 6'd0; issue_rs2 = 6'd0; issue_rd = 6'd3;
    tick();
    issue_rd = 6'd9;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 6'd3; alu_data = 32'h0000_0333;
    #1;
    n_checks++; if (alu_ready !== 1'b1) begin n_errors++; $display("FAIL mid_alu_grant got=%b exp=1", alu_ready); end
    tick();
    rst = 1'b1;
    alu_rd = 6'd9; alu_data = 32'h0000_0999;
    issue_valid = 1'b1; issue_rs1 = 6'd3; issue_rd = 6'd10;
    #1;
    n_checks++; if (wr_en !== 1'b1) begin n_errors++; $display("FAIL mid_in_flight got=%b exp=1", wr_en); end
    n_checks++; if (alu_ready !== 1'b0) begin n_errors++; $display("FAIL mid_rst_alu_ready got=%b exp=0", alu_ready); end
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL mid_rst_issue_ready got=%b exp=0", issue_ready); end
    tick();
    rst = 1'b0; alu_valid = 1'b0;
    issue_rs1 = 6'd3; issue_rs2 = 6'd9; issue_rd = 6'd9;
    #1;
    n_checks++; if (wr_en !== 1'b0) begin n_errors++; $display("FAIL mid_wr_en got=%b exp=0", wr_en); end
    n_checks++; if (idle !== 1'b1) begin n_errors++; $display("FAIL mid_idle got=%b exp=1", idle); end
    n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL mid_busy_cleared got=%b exp=1", issue_ready); end
    issue_valid = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_raw();
    test_round_robin();
    test_rd_zero();
    test_waw();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
